hazard_ctrl: RTL

//  Producer side of the bypass path: tracks in-flight register writers in EX/MEM/WB,

---
 rtl/hazard_ctrl_pkg.sv | 31 +++
 rtl/hazard_ctrl_mdu_timer.sv | 42 ++++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard / bypass controller: register and data word
// types, forward-select encoding, in-flight writer slot record, and the
// source-match helper used by the forwarding logic.
package hazard_ctrl_pkg;

  typedef logic [63:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_WB   = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t dst;
    logic       is_load;
    logic       is_mdu;
  } hz_slot_t;

  localparam hz_slot_t SLOT_EMPTY = '0;

  // A slot feeds a source only when it holds a live writer of that register
  // and the decoding instruction actually reads the source.
  function automatic logic slot_hit(hz_slot_t s, creg_addr_t src, logic use_src);
    return use_src & s.valid & (s.dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// mdu_timer: loadable down-counter that reports how many extra cycles a
// multicycle mul/div still occupies the EX stage. clear dominates load.
module mdu_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] len,
  output logic         busy
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: abort, reload on MDU entry, otherwise count down to zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = len;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy = (count_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks register writers in EX/MEM/WB, produces operand
// forward selects/data for the instruction in ID, and raises stalls for
// load-use and multicycle MDU hazards.
// Optional build macro HAZARD_STATS_EN adds stall / forward cycle counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  creg_addr_t id_srca,
  input  creg_addr_t id_srcb,
  input  logic       id_use_a,
  input  logic       id_use_b,
  input  creg_addr_t id_dst,
  input  logic       id_wen,
  input  logic       id_is_load,
  input  logic       id_is_mdu,
  input  logic       flush,
  input  word_t      ex_result,
  input  word_t      mem_result,
  input  word_t      wb_result,
  output fwd_sel_t   fwd_a_sel,
  output fwd_sel_t   fwd_b_sel,
  output word_t      fwd_a_data,
  output word_t      fwd_b_data,
  output logic       stall_id,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_fwd_count,
`endif
  output logic       ex_busy
);

  localparam int CNT_W = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MDU_LEN = CNT_W'(MDU_LATENCY - 1);

  hz_slot_t ex_q, mem_q, wb_q;
  hz_slot_t ex_d, mem_d, wb_d;
  hz_slot_t id_entry;
  logic     load_use;
  logic     advance;
  logic     mdu_load;

  // Youngest matching writer wins: EX, then MEM, then WB.
  function automatic fwd_sel_t pick_sel(creg_addr_t src, logic use_src,
                                        hz_slot_t ex, hz_slot_t mem, hz_slot_t wb);
    if (slot_hit(ex, src, use_src))       return FWD_EX;
    else if (slot_hit(mem, src, use_src)) return FWD_MEM;
    else if (slot_hit(wb, src, use_src))  return FWD_WB;
    else                                  return FWD_NONE;
  endfunction

  function automatic word_t pick_data(fwd_sel_t s, word_t ex, word_t mem, word_t wb);
    case (s)
      FWD_EX:  return ex;
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return '0;
    endcase
  endfunction

  // Forward selects, load-use detection and stall; load data is not yet
  // available in EX, so a load-use hazard suppresses forwarding.
  always_comb begin
    load_use = ex_q.is_load & (slot_hit(ex_q, id_srca, id_use_a) |
                               slot_hit(ex_q, id_srcb, id_use_b));
    fwd_a_sel = pick_sel(id_srca, id_use_a, ex_q, mem_q, wb_q);
    fwd_b_sel = pick_sel(id_srcb, id_use_b, ex_q, mem_q, wb_q);
    if (load_use) begin
      fwd_a_sel = FWD_NONE;
      fwd_b_sel = FWD_NONE;
    end
    fwd_a_data = pick_data(fwd_a_sel, ex_result, mem_result, wb_result);
    fwd_b_data = pick_data(fwd_b_sel, ex_result, mem_result, wb_result);
    stall_id   = load_use | ex_busy;
  end

  // Slot movement: flush squashes EX/ID, a busy MDU holds EX and bubbles
  // MEM, a load-use inserts a bubble into EX, otherwise everything advances.
  always_comb begin
    id_entry         = SLOT_EMPTY;
    id_entry.valid   = id_valid & id_wen & (id_dst != '0);
    id_entry.dst     = id_dst;
    id_entry.is_load = id_is_load;
    id_entry.is_mdu  = id_is_mdu;
    advance  = 1'b0;
    wb_d     = mem_q;
    if (flush) begin
      ex_d  = SLOT_EMPTY;
      mem_d = SLOT_EMPTY;
    end else if (ex_busy) begin
      ex_d  = ex_q;
      mem_d = SLOT_EMPTY;
    end else if (load_use) begin
      ex_d  = SLOT_EMPTY;
      mem_d = ex_q;
    end else begin
      ex_d    = id_entry;
      mem_d   = ex_q;
      advance = 1'b1;
    end
    mdu_load = advance & id_valid & id_is_mdu;
  end

  // Slot registers; WB retires unconditionally each edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
      wb_q  <= SLOT_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  mdu_timer #(.W(CNT_W)) u_mdu_timer (
    .clk   (clk),
    .reset (reset),
    .load  (mdu_load),
    .clear (flush),
    .len   (MDU_LEN),
    .busy  (ex_busy)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [31:0] stat_fwd_q, stat_fwd_d;

  // Free-running event counters that wrap naturally at 2^32.
  always_comb begin
    stat_stall_d = stat_stall_q + {31'd0, stall_id};
    stat_fwd_d   = stat_fwd_q +
                   {31'd0, (fwd_a_sel != FWD_NONE) | (fwd_b_sel != FWD_NONE)};
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_q <= '0;
      stat_fwd_q   <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_fwd_q   <= stat_fwd_d;
    end
  end

  assign stat_stall_cycles = stat_stall_q;
  assign stat_fwd_count    = stat_fwd_q;
`endif

endmodule
